bpred_update_ctrl: RTL
======================

Name: bpred_update_ctrl

Overview:
- Execute-side counterpart of the fetch branch predictor. Carries each fetch-time prediction (direction, bimodal index/counter, carry bits, predicted target) down a metadata pipeline to execute.
- At execute, compares the prediction against the resolved branch outcome. Drives the predictor's update/recovery inputs (execute_bpredictor_*, execute_missPred, execute_c_r_after_r, execute_isCall) and the memory write payload (up_btb_data, up_carry_data, byte_en).

Parameters:
- PIPE_DEPTH, 2, fetch-to-execute metadata stages (1..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall (same meaning as soin_bpredictor_stall); freezes all state
- f_valid  in  1  fetch slot holds a real instruction
- f_p_dir  in  1  predicted direction from predictor
- f_p_target  in  32  predicted next PC from predictor
- f_bimodal  in  12  {index[7:0], counter[1:0], 2'b00 pad} from predictor
- f_carry  in  9  bit_carry from predictor
- ex_is_branch  in  1  execute instruction is a control transfer
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved target
- ex_PC4  in  32  execute instruction PC+4
- ex_is_call  in  1  resolved call
- ex_is_ret  in  1  resolved return
- execute_bpredictor_update  out  1  write enable request
- execute_bpredictor_PC4  out  32
- execute_bpredictor_target  out  32
- execute_bpredictor_dir  out  1
- execute_bpredictor_miss  out  1
- execute_bpredictor_bimodal  out  12
- execute_missPred  out  1  one-cycle redirect/RAS-recovery pulse
- execute_c_r_after_r  out  1  call/return resolved directly after a return
- execute_isCall  out  1
- up_btb_data  out  30  ex_target[31:2]
- up_carry_data  out  9  carried f_carry
- byte_en  out  4  4'b1111 = BTB+bimodal write, 4'b0001 = bimodal only

Behaviour:
- Reset: every stage valid=0. Every output 0, except byte_en=4'b0001. last_ret=0.
- Metadata pipeline: stage0 captures {f_valid, f_p_dir, f_p_target, f_bimodal, f_carry} on each non-stall cycle. Stage k captures stage k-1. The last stage pairs with the ex_* inputs in the same cycle.
- stall=1: no stage shifts. Outputs hold their values, except execute_bpredictor_update and execute_missPred, which are 0.
- Resolve (last stage valid, ex_is_branch=1, stall=0):
  - miss = (p_dir != ex_taken) | (ex_taken & p_target != ex_target).
  - Outputs are registered, 1 cycle after resolve: update=1, PC4=ex_PC4, target=ex_target, dir=ex_taken, miss=miss, bimodal=carried value, missPred=miss.
  - isCall = ex_is_call.
  - c_r_after_r = (ex_is_call | ex_is_ret) & last_ret.
  - byte_en = 4'b1111 if ex_taken & (p_target != ex_target), else 4'b0001.
- Non-branch or invalid last stage: update=0, missPred=0. Data outputs hold.
- last_ret: updates only on resolve, last_ret <= ex_is_ret. Unchanged otherwise.
- Flush: the cycle after a resolve with miss=1, all stages including stage0 load valid=0. Wrong-path metadata never produces an update. A fetch captured during the flush cycle is discarded.
- Simultaneous flush and stall: the flush is deferred until the first non-stall cycle and is not lost.
- Reset asserted mid-operation: clears all state in the next cycle. Any pending flush is cancelled.
- Widths are exact. No arithmetic beyond equality compares.

Test Plan:
1. Reset, then one correctly predicted taken branch (p_dir=1, p_target=ex_target=0x100) -> 1 cycle after resolve: update=1, miss=0, missPred=0, byte_en=4'b0001.
2. Predicted not-taken, resolved taken to 0x200 -> miss=1, missPred=1, byte_en=4'b1111, up_btb_data=0x80; next PIPE_DEPTH fetches produce no update.
3. Return resolved, then call resolved -> call's execute_c_r_after_r=1, execute_isCall=1; a following return gives c_r_after_r=0.
4. stall=1 for 3 cycles with a branch in the last stage -> update=0 throughout, outputs held; resolves correctly on the first non-stall cycle.
5. Mispredict coincident with stall -> flush is applied on the first non-stall cycle and the wrong-path branch generates no update.
6. Reset asserted with valid stages in flight -> all outputs 0 and byte_en=4'b0001 next cycle; subsequent fetches resolve normally.

Source files
------------

// File: rtl/bpred_update_ctrl.sv
// Execute-side branch predictor update controller: carries fetch-time prediction
// metadata to execute, detects mispredicts, and drives predictor update/recovery.
module bpred_update_ctrl #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        f_valid,
  input  logic        f_p_dir,
  input  logic [31:0] f_p_target,
  input  logic [11:0] f_bimodal,
  input  logic [8:0]  f_carry,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_PC4,
  input  logic        ex_is_call,
  input  logic        ex_is_ret,
  output logic        execute_bpredictor_update,
  output logic [31:0] execute_bpredictor_PC4,
  output logic [31:0] execute_bpredictor_target,
  output logic        execute_bpredictor_dir,
  output logic        execute_bpredictor_miss,
  output logic [11:0] execute_bpredictor_bimodal,
  output logic        execute_missPred,
  output logic        execute_c_r_after_r,
  output logic        execute_isCall,
  output logic [29:0] up_btb_data,
  output logic [8:0]  up_carry_data,
  output logic [3:0]  byte_en
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic        stg_valid_q  [PIPE_DEPTH];
  logic        stg_valid_d  [PIPE_DEPTH];
  logic        stg_dir_q    [PIPE_DEPTH];
  logic        stg_dir_d    [PIPE_DEPTH];
  logic [31:0] stg_target_q [PIPE_DEPTH];
  logic [31:0] stg_target_d [PIPE_DEPTH];
  logic [11:0] stg_bimodal_q[PIPE_DEPTH];
  logic [11:0] stg_bimodal_d[PIPE_DEPTH];
  logic [8:0]  stg_carry_q  [PIPE_DEPTH];
  logic [8:0]  stg_carry_d  [PIPE_DEPTH];

  logic        flush_q, flush_d;
  logic        last_ret_q, last_ret_d;

  logic        update_q, update_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] target_q, target_d;
  logic        dir_q, dir_d;
  logic        miss_q, miss_d;
  logic [11:0] bimodal_q, bimodal_d;
  logic        miss_pred_q, miss_pred_d;
  logic        c_r_after_r_q, c_r_after_r_d;
  logic        is_call_q, is_call_d;
  logic [29:0] btb_data_q, btb_data_d;
  logic [8:0]  carry_data_q, carry_data_d;
  logic [3:0]  byte_en_q, byte_en_d;

  logic resolve;
  logic tgt_diff;
  logic miss;

  // A pending flush blocks resolution so the wrong-path branch in the last stage is ignored.
  always_comb begin
    resolve  = stg_valid_q[LAST] & ex_is_branch & ~stall & ~flush_q;
    tgt_diff = (stg_target_q[LAST] != ex_target);
    miss     = (stg_dir_q[LAST] != ex_taken) | (ex_taken & tgt_diff);
  end

  always_comb begin
    stg_valid_d   = stg_valid_q;
    stg_dir_d     = stg_dir_q;
    stg_target_d  = stg_target_q;
    stg_bimodal_d = stg_bimodal_q;
    stg_carry_d   = stg_carry_q;
    if (!stall) begin
      stg_valid_d[0]   = f_valid & ~flush_q;
      stg_dir_d[0]     = f_p_dir;
      stg_target_d[0]  = f_p_target;
      stg_bimodal_d[0] = f_bimodal;
      stg_carry_d[0]   = f_carry;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        stg_valid_d[k]   = stg_valid_q[k-1] & ~flush_q;
        stg_dir_d[k]     = stg_dir_q[k-1];
        stg_target_d[k]  = stg_target_q[k-1];
        stg_bimodal_d[k] = stg_bimodal_q[k-1];
        stg_carry_d[k]   = stg_carry_q[k-1];
      end
    end
  end

  // A flush raised just before a stall survives until the stall drops.
  always_comb begin
    flush_d    = stall ? flush_q : (resolve & miss);
    last_ret_d = resolve ? ex_is_ret : last_ret_q;
  end

  always_comb begin
    update_d      = resolve;
    miss_pred_d   = resolve & miss;
    pc4_d         = pc4_q;
    target_d      = target_q;
    dir_d         = dir_q;
    miss_d        = miss_q;
    bimodal_d     = bimodal_q;
    c_r_after_r_d = c_r_after_r_q;
    is_call_d     = is_call_q;
    btb_data_d    = btb_data_q;
    carry_data_d  = carry_data_q;
    byte_en_d     = byte_en_q;
    if (resolve) begin
      pc4_d         = ex_PC4;
      target_d      = ex_target;
      dir_d         = ex_taken;
      miss_d        = miss;
      bimodal_d     = stg_bimodal_q[LAST];
      c_r_after_r_d = (ex_is_call | ex_is_ret) & last_ret_q;
      is_call_d     = ex_is_call;
      btb_data_d    = ex_target[31:2];
      carry_data_d  = stg_carry_q[LAST];
      byte_en_d     = (ex_taken & tgt_diff) ? 4'b1111 : 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        stg_valid_q[k]   <= 1'b0;
        stg_dir_q[k]     <= 1'b0;
        stg_target_q[k]  <= 32'd0;
        stg_bimodal_q[k] <= 12'd0;
        stg_carry_q[k]   <= 9'd0;
      end
      flush_q       <= 1'b0;
      last_ret_q    <= 1'b0;
      update_q      <= 1'b0;
      pc4_q         <= 32'd0;
      target_q      <= 32'd0;
      dir_q         <= 1'b0;
      miss_q        <= 1'b0;
      bimodal_q     <= 12'd0;
      miss_pred_q   <= 1'b0;
      c_r_after_r_q <= 1'b0;
      is_call_q     <= 1'b0;
      btb_data_q    <= 30'd0;
      carry_data_q  <= 9'd0;
      byte_en_q     <= 4'b0001;
    end else begin
      stg_valid_q   <= stg_valid_d;
      stg_dir_q     <= stg_dir_d;
      stg_target_q  <= stg_target_d;
      stg_bimodal_q <= stg_bimodal_d;
      stg_carry_q   <= stg_carry_d;
      flush_q       <= flush_d;
      last_ret_q    <= last_ret_d;
      update_q      <= update_d;
      pc4_q         <= pc4_d;
      target_q      <= target_d;
      dir_q         <= dir_d;
      miss_q        <= miss_d;
      bimodal_q     <= bimodal_d;
      miss_pred_q   <= miss_pred_d;
      c_r_after_r_q <= c_r_after_r_d;
      is_call_q     <= is_call_d;
      btb_data_q    <= btb_data_d;
      carry_data_q  <= carry_data_d;
      byte_en_q     <= byte_en_d;
    end
  end

  assign execute_bpredictor_update  = update_q;
  assign execute_bpredictor_PC4     = pc4_q;
  assign execute_bpredictor_target  = target_q;
  assign execute_bpredictor_dir     = dir_q;
  assign execute_bpredictor_miss    = miss_q;
  assign execute_bpredictor_bimodal = bimodal_q;
  assign execute_missPred           = miss_pred_q;
  assign execute_c_r_after_r        = c_r_after_r_q;
  assign execute_isCall             = is_call_q;
  assign up_btb_data                = btb_data_q;
  assign up_carry_data              = carry_data_q;
  assign byte_en                    = byte_en_q;

endmodule
